alu_issue_stage: RTL and testbench

- Decode/issue stage that drives the ALU operand/control interface (`in_a`, `in_b`, `alu_control`) from a 32-bit RV32I instruction plus register-file read data.
- Decodes the ALU opcode, selects operands (register, immediate, PC), and registers everything into the ID/EX pipeline register.
- Valid/ready handshakes on both sides, with flush support.
- Sits between fetch/register-read and the execute stage that instantiates `alu`.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/alu_decoder.sv | 103 ++++++++++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU op codes, opcode constants and
// immediate formats used by the issue stage and its decoder.
package riscv_pkg;

    // ALU control encoding consumed by the execute-stage alu.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_SHAMT
    } imm_fmt_t;

    // Build a 32-bit immediate; everything sign-extends except shamt.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

    // Base operation selected by funct3 for register and immediate ALU forms.
    function automatic alu_op_t f3_to_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decoder: instruction + PC + register data to ALU op,
// operands and control flags for the ID/EX register.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_op_t     alu_op,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        is_branch,
    output logic [2:0]  funct3,
    output logic [31:0] store_data,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       writes_rd;

    assign opcode     = instr[6:0];
    assign funct7     = instr[31:25];
    assign funct3     = instr[14:12];
    assign rd         = instr[11:7];
    assign store_data = rs2_data;
    // Illegal instructions never write; x0 is never written.
    assign reg_write  = writes_rd && !illegal && (rd != 5'd0);

    // Opcode decode: operand selection, ALU op and legality.
    always_comb begin
        // NOTE: every signal gets a default first so no decode path infers a latch.
        alu_op    = ALU_ADD;
        op_a      = '0;
        op_b      = '0;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                op_a      = rs1_data;
                op_b      = rs2_data;
                writes_rd = 1'b1;
                alu_op    = f3_to_op(funct3);
                if (funct7 == F7_ALT && funct3 == 3'b000)
                    alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    alu_op = ALU_SRA;
                else if (funct7 != F7_BASE)
                    illegal = 1'b1;
            end
            OP_IMM: begin
                op_a      = rs1_data;
                writes_rd = 1'b1;
                alu_op    = f3_to_op(funct3);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    op_b = imm_gen(instr, IMM_SHAMT);
                    if (funct3 == 3'b101 && funct7 == F7_ALT)
                        alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE)
                        illegal = 1'b1;
                end else begin
                    op_b = imm_gen(instr, IMM_I);
                end
            end
            OP_LUI: begin
                op_b      = imm_gen(instr, IMM_U);
                alu_op    = ALU_PASS_B;
                writes_rd = 1'b1;
            end
            OP_AUIPC: begin
                op_a      = pc;
                op_b      = imm_gen(instr, IMM_U);
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                op_a      = rs1_data;
                op_b      = imm_gen(instr, IMM_I);
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                op_a = rs1_data;
                op_b = imm_gen(instr, IMM_S);
            end
            OP_BRANCH: begin
                op_a      = rs1_data;
                op_b      = rs2_data;
                is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: valid/ready handshake and ID/EX pipeline register
// feeding the ALU. Optional perf counters under ALU_ISSUE_PERF_CNT_EN.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in_a,
    output logic [XLEN-1:0] out_in_b,
    output logic [3:0]      out_alu_control,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_branch,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    alu_op_t     dec_op;
    logic [31:0] dec_a, dec_b, dec_store;
    logic [4:0]  dec_rd;
    logic        dec_reg_write, dec_is_branch, dec_illegal;
    logic [2:0]  dec_funct3;
    logic        accept;

    alu_decoder u_decoder (
        .instr      (in_instr),
        .pc         (in_pc),
        .rs1_data   (in_rs1_data),
        .rs2_data   (in_rs2_data),
        .alu_op     (dec_op),
        .op_a       (dec_a),
        .op_b       (dec_b),
        .rd         (dec_rd),
        .reg_write  (dec_reg_write),
        .is_branch  (dec_is_branch),
        .funct3     (dec_funct3),
        .store_data (dec_store),
        .illegal    (dec_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // ID/EX register: reset beats flush, flush beats load, load beats drain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the payload is cleared too so all outputs read zero straight after reset.
            out_valid       <= 1'b0;
            out_in_a        <= '0;
            out_in_b        <= '0;
            out_alu_control <= '0;
            out_rd          <= '0;
            out_reg_write   <= 1'b0;
            out_is_branch   <= 1'b0;
            out_funct3      <= '0;
            out_store_data  <= '0;
            out_pc          <= '0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_in_a        <= dec_a;
            out_in_b        <= dec_b;
            out_alu_control <= dec_op;
            out_rd          <= dec_rd;
            out_reg_write   <= dec_reg_write;
            out_is_branch   <= dec_is_branch;
            out_funct3      <= dec_funct3;
            out_store_data  <= dec_store;
            out_pc          <= in_pc;
            out_illegal     <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    // Issue and stall counters; wrap naturally, survive flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (out_valid && out_ready)
                perf_issued <= perf_issued + 32'd1;
            if (out_valid && !out_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: transaction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        ill;
        logic        care;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_in_a, out_in_b, out_store_data, out_pc;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_is_branch, out_illegal;
    logic [2:0]  out_funct3;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
    logic [31:0] m_issued = '0;
    logic [31:0] m_stall = '0;
`endif

    int   n_tests = 0;
    int   n_fail = 0;
    logic started = 1'b0;
    logic mv = 1'b0;
    exp_t me = '0;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_in_a        (out_in_a),
        .out_in_b        (out_in_b),
        .out_alu_control (out_alu_control),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_is_branch   (out_is_branch),
        .out_funct3      (out_funct3),
        .out_store_data  (out_store_data),
        .out_pc          (out_pc),
        .out_illegal     (out_illegal)
`ifdef ALU_ISSUE_PERF_CNT_EN
        ,
        .perf_issued     (perf_issued),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What an instruction must issue as, derived from mnemonic-level rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [3:0] tbl [8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic       wr;
        // funct3 -> ADD SLL SLT SLTU XOR SRL OR AND
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.rd = ins[11:7];
        e.f3 = f3;
        e.sd = r2;
        e.pc = pc;
        e.care = 1'b1;
        wr = 1'b0;
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2; wr = 1'b1;
                if (f7 == 7'h00) e.op = tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd7;
                else begin e.ill = 1'b1; e.care = 1'b0; end
            end
            7'h13: begin
                e.a = r1; wr = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = {27'd0, ins[24:20]};
                    if (f7 == 7'h00) e.op = tbl[f3];
                    else if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'd7;
                    else begin e.ill = 1'b1; e.care = 1'b0; end
                end else begin
                    e.b = 32'($signed(ins[31:20]));
                    e.op = tbl[f3];
                end
            end
            7'h37: begin e.b = ins & 32'hFFFF_F000; e.op = 4'd10; wr = 1'b1; end
            7'h17: begin e.a = pc; e.b = ins & 32'hFFFF_F000; wr = 1'b1; end
            7'h03: begin e.a = r1; e.b = 32'($signed(ins[31:20])); wr = 1'b1; end
            7'h23: begin e.a = r1; e.b = 32'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin
                e.a = r1; e.b = r2; e.br = 1'b1;
                case (f3)
                    3'd0, 3'd1: e.op = 4'd1;
                    3'd4, 3'd5: e.op = 4'd8;
                    3'd6, 3'd7: e.op = 4'd9;
                    default: begin e.ill = 1'b1; e.care = 1'b0; end
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        e.rw = wr && !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    // Reference stage behaviour at each clock edge.
    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            mv <= 1'b0;
`ifdef ALU_ISSUE_PERF_CNT_EN
            m_issued <= '0;
            m_stall <= '0;
`endif
        end else begin
`ifdef ALU_ISSUE_PERF_CNT_EN
            if (mv && out_ready) m_issued <= m_issued + 1;
            if (mv && !out_ready) m_stall <= m_stall + 1;
`endif
            if (flush) mv <= 1'b0;
            else if (in_valid && (!mv || out_ready)) begin
                mv <= 1'b1;
                me <= ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
            end else if (out_ready) mv <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, mv});
            check("in_ready", {31'd0, in_ready}, {31'd0, (!mv || out_ready)});
            if (mv) begin
                check("rd", {27'd0, out_rd}, {27'd0, me.rd});
                check("reg_write", {31'd0, out_reg_write}, {31'd0, me.rw});
                check("is_branch", {31'd0, out_is_branch}, {31'd0, me.br});
                check("funct3", {29'd0, out_funct3}, {29'd0, me.f3});
                check("store_data", out_store_data, me.sd);
                check("pc", out_pc, me.pc);
                check("illegal", {31'd0, out_illegal}, {31'd0, me.ill});
                if (me.care) begin
                    check("in_a", out_in_a, me.a);
                    check("in_b", out_in_b, me.b);
                    check("alu_control", {28'd0, out_alu_control}, {28'd0, me.op});
                end
            end
`ifdef ALU_ISSUE_PERF_CNT_EN
            check("perf_issued", perf_issued, m_issued);
            check("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid = v;
        in_instr = ins;
        in_pc = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        out_ready = ordy;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, with out_ready low to show in_ready comes from out_valid alone.
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset in_a", out_in_a, 32'd0);
        check("reset in_b", out_in_b, 32'd0);
        check("reset pc", out_pc, 32'd0);
        check("reset reg_write", {31'd0, out_reg_write}, 32'd0);
        reset = 1'b0;

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
        check("add valid", {31'd0, out_valid}, 32'd1);
        check("add in_a", out_in_a, 32'd5);
        check("add in_b", out_in_b, 32'd7);
        check("add op", {28'd0, out_alu_control}, 32'h0);
        check("add rd", {27'd0, out_rd}, 32'd3);
        check("add reg_write", {31'd0, out_reg_write}, 32'd1);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h104, 32'd0, 32'd0, 1'b1, 1'b0);
        check("addi in_b", out_in_b, 32'hFFFF_FFFF);
        check("addi op", {28'd0, out_alu_control}, 32'h0);
        // srai x2,x1,4
        drive(1'b1, 32'h4040D113, 32'h108, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        check("srai in_b", out_in_b, 32'd4);
        check("srai op", {28'd0, out_alu_control}, 32'h7);
        // lui x5,0x12345
        drive(1'b1, 32'h123452B7, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b0);
        check("lui in_b", out_in_b, 32'h1234_5000);
        check("lui op", {28'd0, out_alu_control}, 32'hA);
        // beq x1,x2
        drive(1'b1, 32'h00208463, 32'h110, 32'd3, 32'd3, 1'b1, 1'b0);
        check("beq op", {28'd0, out_alu_control}, 32'h1);
        check("beq is_branch", {31'd0, out_is_branch}, 32'd1);
        check("beq reg_write", {31'd0, out_reg_write}, 32'd0);
        // sw x2,8(x1)
        drive(1'b1, 32'h0020A423, 32'h114, 32'h1000, 32'hCAFE_F00D, 1'b1, 1'b0);
        check("sw in_b", out_in_b, 32'd8);
        check("sw store_data", out_store_data, 32'hCAFE_F00D);
        // lw x4,-4(x1)
        drive(1'b1, 32'hFFC0A203, 32'h118, 32'h2000, 32'd0, 1'b1, 1'b0);
        check("lw in_b", out_in_b, 32'hFFFF_FFFC);
        // auipc x6,0x1
        drive(1'b1, 32'h00001317, 32'h2000, 32'd9, 32'd9, 1'b1, 1'b0);
        check("auipc in_a", out_in_a, 32'h2000);
        check("auipc in_b", out_in_b, 32'h1000);
        // sub, sltu, blt, xori -2048, add to x0
        drive(1'b1, 32'h402081B3, 32'h11C, 32'd10, 32'd3, 1'b1, 1'b0);
        drive(1'b1, 32'h0020B1B3, 32'h120, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(1'b1, 32'h0020C463, 32'h124, 32'd1, 32'd2, 1'b1, 1'b0);
        drive(1'b1, 32'h8000C293, 32'h128, 32'h55, 32'd0, 1'b1, 1'b0);
        check("xori in_b", out_in_b, 32'hFFFF_F800);
        drive(1'b1, 32'h00208033, 32'h12C, 32'd1, 32'd1, 1'b1, 1'b0);
        check("add x0 reg_write", {31'd0, out_reg_write}, 32'd0);
        // Unknown opcode, mul (funct7=1), slli with funct7=0100000
        drive(1'b1, 32'h0000007F, 32'h130, 32'd4, 32'd4, 1'b1, 1'b0);
        check("ill opcode illegal", {31'd0, out_illegal}, 32'd1);
        check("ill opcode valid", {31'd0, out_valid}, 32'd1);
        check("ill opcode reg_write", {31'd0, out_reg_write}, 32'd0);
        check("ill opcode in_a", out_in_a, 32'd0);
        drive(1'b1, 32'h022081B3, 32'h134, 32'd4, 32'd4, 1'b1, 1'b0);
        check("mul illegal", {31'd0, out_illegal}, 32'd1);
        check("mul reg_write", {31'd0, out_reg_write}, 32'd0);
        drive(1'b1, 32'h40109093, 32'h138, 32'd4, 32'd4, 1'b1, 1'b0);

        // Backpressure: hold A for three cycles while B waits at the input.
        drive(1'b1, 32'h002081B3, 32'h300, 32'd11, 32'd22, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h402081B3, 32'h304, 32'd50, 32'd8, 1'b0, 1'b0);
            check("stall pc held", out_pc, 32'h300);
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        drive(1'b1, 32'h402081B3, 32'h304, 32'd50, 32'd8, 1'b1, 1'b0);
        check("b2b first pc", out_pc, 32'h304);
        drive(1'b1, 32'h0020B1B3, 32'h308, 32'd6, 32'd7, 1'b1, 1'b0);
        check("b2b second pc", out_pc, 32'h308);
        check("b2b valid", {31'd0, out_valid}, 32'd1);

        // Flush with a held instruction and an accepted incoming one.
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h002081B3, 32'h400, 32'd1, 32'd1, 1'b1, 1'b1);
        check("flush valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush dropped", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a stall.
        drive(1'b1, 32'h123452B7, 32'h500, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h504, 32'd0, 32'd0, 1'b0, 1'b0);
        check("reset mid-stall valid", {31'd0, out_valid}, 32'd0);
        check("reset mid-stall pc", out_pc, 32'd0);
        reset = 1'b0;

        // Drain.
        drive(1'b1, 32'hFFF00093, 32'h600, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
